m68k_sdram_controller: RTL

- SDRAM-side responder for the 68k cache controller's DRAM interface.
- Accepts select, strobes and aligned addresses from the cache controller.
- Issues SDRAM init, auto-refresh, 8-word burst reads and single-word writes.
- Returns burst data with fixed CAS latency 2, and a write DTACK.
- Target device: 16M x 16 SDRAM (4 banks, 8192 rows, 512 columns). Module sits between the cache controller and the SDRAM pins.

---
 rtl/m68k_sdram_controller.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/m68k_sdram_controller.sv
// m68k_sdram_controller: SDRAM-side responder for the 68k cache controller.
// Runs the SDRAM power-up sequence, periodic auto-refresh, 8-word burst reads
// (CAS latency 2, auto-precharge) and single-word writes with a DTACK handshake.
// Optional build macro SDRAM_FAST_INIT_EN shortens the power-up wait to
// 16 clocks for simulation; the refresh interval is unaffected.
module m68k_sdram_controller #(
   parameter int INIT_WAIT        = 5000,
   parameter int REFRESH_INTERVAL = 375,
   parameter int TRCD             = 2,
   parameter int TRP              = 2,
   parameter int TRFC             = 7
) (
   input  logic        Clock,
   input  logic        Reset_L,
   input  logic        DramSelect_L,
   input  logic        AS_L,
   input  logic        WE_L,
   input  logic        UDS_L,
   input  logic        LDS_L,
   input  logic [31:0] Address,
   input  logic [15:0] DataIn,
   output logic [15:0] DataOut,
   output logic        Dtack_L,
   output logic        SDram_CKE_H,
   output logic        SDram_CS_L,
   output logic        SDram_RAS_L,
   output logic        SDram_CAS_L,
   output logic        SDram_WE_L,
   output logic [1:0]  SDram_BA,
   output logic [12:0] SDram_Addr,
   output logic [1:0]  SDram_DQM,
   inout  wire  [15:0] SDram_DQ,
   output logic [4:0]  ControllerState
);

`ifdef SDRAM_FAST_INIT_EN
   localparam int INIT_CYCLES = 16;
`else
   localparam int INIT_CYCLES = INIT_WAIT;
`endif

   // {CS_L, RAS_L, CAS_L, WE_L}
   localparam logic [3:0]  CMD_NOP   = 4'b0111;
   localparam logic [3:0]  CMD_ACT   = 4'b0011;
   localparam logic [3:0]  CMD_READ  = 4'b0101;
   localparam logic [3:0]  CMD_WRITE = 4'b0100;
   localparam logic [3:0]  CMD_PRE   = 4'b0010;
   localparam logic [3:0]  CMD_REF   = 4'b0001;
   localparam logic [3:0]  CMD_LMR   = 4'b0000;
   // Burst length 8, sequential, CL2, single-location write burst
   localparam logic [12:0] MODE_WORD = 13'b000_1_00_010_0_011;
   localparam logic [15:0] REF_LAST  = 16'(REFRESH_INTERVAL - 1);

   typedef enum logic [4:0] {
      InitWait, PrechargeAll, PrechargeWait, InitRefresh, InitRefreshWait,
      LoadMode, LoadModeWait, Idle, Refresh, RefreshWait, Active, ActiveWait,
      ReadCmd, ReadBurst, ReadPrecharge, ReadDone, WriteCmd, WriteAck, WriteRecover
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] ref_cnt_q, ref_cnt_d;
   logic        ref_pend_q, ref_pend_d;
   logic        init_done_q, init_done_d;
   logic        second_ref_q, second_ref_d;
   logic [10:0] req_addr_q, req_addr_d;   // {bank, column}
   logic [3:0]  cmd_q, cmd_d;
   logic [12:0] addr_q, addr_d;
   logic [1:0]  ba_q, ba_d;
   logic [1:0]  dqm_q, dqm_d;
   logic        dq_oe_q, dq_oe_d;
   logic [15:0] dq_out_q, dq_out_d;
   logic [15:0] data_out_q, data_out_d;
   logic        dtack_q, dtack_d;
   logic        ref_wrap_s;
   logic        unused_addr_s;

   assign unused_addr_s   = ^{Address[31:25], Address[0]};
   assign SDram_CKE_H     = 1'b1;
   assign {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L} = cmd_q;
   assign SDram_BA        = ba_q;
   assign SDram_Addr      = addr_q;
   assign SDram_DQM       = dqm_q;
   assign SDram_DQ        = dq_oe_q ? dq_out_q : {16{1'bz}};
   assign DataOut         = data_out_q;
   assign Dtack_L         = dtack_q;
   assign ControllerState = state_q;

   // Next-state, next-command and refresh bookkeeping; commands on the pins
   // always belong to the state currently held in state_q.
   always_comb begin
      state_d      = state_q;
      cnt_d        = (cnt_q != 16'd0) ? (cnt_q - 16'd1) : 16'd0;
      init_done_d  = init_done_q;
      second_ref_d = second_ref_q;
      req_addr_d   = req_addr_q;
      cmd_d        = CMD_NOP;
      addr_d       = 13'd0;
      ba_d         = 2'd0;
      dqm_d        = 2'b11;
      dq_oe_d      = 1'b0;
      dq_out_d     = 16'd0;
      data_out_d   = SDram_DQ;
      dtack_d      = 1'b1;

      ref_wrap_s = init_done_q && (ref_cnt_q == REF_LAST);
      if (!init_done_q || ref_wrap_s) begin
         ref_cnt_d = 16'd0;
      end else begin
         ref_cnt_d = ref_cnt_q + 16'd1;
      end
      // A wrap while already pending simply leaves one refresh pending
      ref_pend_d = ref_pend_q | ref_wrap_s;

      case (state_q)
         InitWait: begin
            if (cnt_q == 16'd0) begin
               state_d = PrechargeAll;
               cmd_d   = CMD_PRE;
               addr_d  = 13'h0400;
            end else begin
               state_d = InitWait;
            end
         end
         PrechargeAll: begin
            state_d = PrechargeWait;
            cnt_d   = 16'(TRP - 1);
         end
         PrechargeWait: begin
            if (cnt_q == 16'd0) begin
               state_d = InitRefresh;
               cmd_d   = CMD_REF;
            end else begin
               state_d = PrechargeWait;
            end
         end
         InitRefresh: begin
            state_d = InitRefreshWait;
            cnt_d   = 16'(TRFC - 1);
         end
         InitRefreshWait: begin
            if (cnt_q != 16'd0) begin
               state_d = InitRefreshWait;
            end else if (second_ref_q) begin
               state_d = LoadMode;
               cmd_d   = CMD_LMR;
               addr_d  = MODE_WORD;
            end else begin
               state_d      = InitRefresh;
               cmd_d        = CMD_REF;
               second_ref_d = 1'b1;
            end
         end
         LoadMode: begin
            state_d = LoadModeWait;
            cnt_d   = 16'd1;
         end
         LoadModeWait: begin
            if (cnt_q == 16'd0) begin
               state_d     = Idle;
               init_done_d = 1'b1;
            end else begin
               state_d = LoadModeWait;
            end
         end
         Idle: begin
            if (ref_pend_q) begin
               state_d    = Refresh;
               cmd_d      = CMD_REF;
               ref_pend_d = ref_wrap_s;
            end else if (!DramSelect_L && !AS_L) begin
               state_d    = Active;
               cmd_d      = CMD_ACT;
               addr_d     = Address[24:12];
               ba_d       = Address[11:10];
               req_addr_d = Address[11:1];
            end else begin
               state_d = Idle;
            end
         end
         Refresh: begin
            // The Idle decision cycle supplies the final NOP of tRFC, so the
            // next command can land exactly TRFC clocks after the refresh.
            state_d = RefreshWait;
            cnt_d   = 16'(TRFC - 3);
         end
         RefreshWait: begin
            if (cnt_q == 16'd0) begin
               state_d = Idle;
            end else begin
               state_d = RefreshWait;
            end
         end
         Active: begin
            state_d = ActiveWait;
            cnt_d   = 16'(TRCD - 2);
         end
         ActiveWait: begin
            if (cnt_q != 16'd0) begin
               state_d = ActiveWait;
            end else if (WE_L) begin
               state_d = ReadCmd;
               cmd_d   = CMD_READ;
               addr_d  = {2'b00, 1'b1, 1'b0, req_addr_q[8:0]};
               ba_d    = req_addr_q[10:9];
               dqm_d   = 2'b00;
            end else begin
               state_d  = WriteCmd;
               cmd_d    = CMD_WRITE;
               addr_d   = {2'b00, 1'b1, 1'b0, req_addr_q[8:0]};
               ba_d     = req_addr_q[10:9];
               dqm_d    = {UDS_L, LDS_L};
               dq_oe_d  = 1'b1;
               dq_out_d = DataIn;
            end
         end
         ReadCmd: begin
            state_d = ReadBurst;
            cnt_d   = 16'd9;
            dqm_d   = 2'b00;
         end
         ReadBurst: begin
            // Covers the CL2 pipeline plus the 8 words landing on DataOut
            if (cnt_q == 16'd0) begin
               state_d = ReadPrecharge;
               cnt_d   = 16'(TRP - 1);
            end else begin
               state_d = ReadBurst;
               dqm_d   = 2'b00;
            end
         end
         ReadPrecharge: begin
            if (cnt_q == 16'd0) begin
               state_d = ReadDone;
            end else begin
               state_d = ReadPrecharge;
            end
         end
         ReadDone: begin
            if (DramSelect_L) begin
               state_d = Idle;
            end else begin
               state_d = ReadDone;
            end
         end
         WriteCmd: begin
            state_d = WriteAck;
            dtack_d = 1'b0;
         end
         WriteAck: begin
            if (AS_L || DramSelect_L) begin
               state_d = WriteRecover;
               cnt_d   = 16'(TRP);
            end else begin
               state_d = WriteAck;
               dtack_d = 1'b0;
            end
         end
         WriteRecover: begin
            if (cnt_q == 16'd0) begin
               state_d = Idle;
            end else begin
               state_d = WriteRecover;
            end
         end
         default: begin
            state_d = InitWait;
            cnt_d   = 16'(INIT_CYCLES - 1);
         end
      endcase
   end

   // Register state and every pin output; reset restarts the init sequence
   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q      <= InitWait;
         cnt_q        <= 16'(INIT_CYCLES - 1);
         ref_cnt_q    <= 16'd0;
         ref_pend_q   <= 1'b0;
         init_done_q  <= 1'b0;
         second_ref_q <= 1'b0;
         req_addr_q   <= 11'd0;
         cmd_q        <= CMD_NOP;
         addr_q       <= 13'd0;
         ba_q         <= 2'd0;
         dqm_q        <= 2'b11;
         dq_oe_q      <= 1'b0;
         dq_out_q     <= 16'd0;
         data_out_q   <= 16'd0;
         dtack_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ref_cnt_q    <= ref_cnt_d;
         ref_pend_q   <= ref_pend_d;
         init_done_q  <= init_done_d;
         second_ref_q <= second_ref_d;
         req_addr_q   <= req_addr_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         ba_q         <= ba_d;
         dqm_q        <= dqm_d;
         dq_oe_q      <= dq_oe_d;
         dq_out_q     <= dq_out_d;
         data_out_q   <= data_out_d;
         dtack_q      <= dtack_d;
      end
   end

endmodule
